// File: rtl/rl_pair_feeder.sv
// rl_pair_feeder
//   Pair-generation front end for the range-limited LJ force tile. Walks every
//   (reference i, neighbor j) combination of a home cell against a neighbor
//   cell, reads both particle words from 1-cycle-latency memories and streams
//   the pairs out through a 2-entry buffer with a valid/ready handshake.
//
// Ports
//   clock, resetn            clock and synchronous active-low reset
//   start                    one-cycle pulse, accepted only in IDLE
//   home_num, neighbor_num   particle counts, latched at the accepted start
//   same_cell                neighbor cell is the home cell, latched at start
//   home_rd_addr/_data       home memory read port (data one cycle after addr)
//   neighbor_rd_addr/_data   neighbor memory read port
//   reference, neighbor      packed {w,z,y,x} words of the presented pair
//   ref_id, neighbor_id      i and j of the presented pair
//   ovalid, iready           output handshake
//   busy, done               pass in progress / one-cycle completion pulse
//
// Build option
//   RL_PAIR_FEEDER_SKIP_SELF_EN  when defined, i==j pairs are never issued for
//                                a pass started with same_cell=1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing one memory read per free buffer slot
// DRAIN | all reads issued; waiting for buffer and read pipe to empty
// DONE  | one-cycle done pulse

module rl_pair_feeder #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] home_num,
  input  logic [PARTICLE_ID_WIDTH-1:0] neighbor_num,
  input  logic                         same_cell,
  output logic [PARTICLE_ID_WIDTH-1:0] home_rd_addr,
  input  logic [4*DATA_WIDTH-1:0]      home_rd_data,
  output logic [PARTICLE_ID_WIDTH-1:0] neighbor_rd_addr,
  input  logic [4*DATA_WIDTH-1:0]      neighbor_rd_data,
  output logic [4*DATA_WIDTH-1:0]      reference,
  output logic [4*DATA_WIDTH-1:0]      neighbor,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [PARTICLE_ID_WIDTH-1:0] neighbor_id,
  output logic                         ovalid,
  input  logic                         iready,
  output logic                         busy,
  output logic                         done
);

  localparam int IW = PARTICLE_ID_WIDTH;
  localparam int WW = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] home_num_q, home_num_d;
  logic [IW-1:0] nbr_num_q, nbr_num_d;
  logic          skip_q, skip_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic          inflight_q, inflight_d;
  logic [IW-1:0] tag_i_q, tag_i_d;
  logic [IW-1:0] tag_j_q, tag_j_d;

  logic [WW-1:0] fifo_ref_q [2];
  logic [WW-1:0] fifo_ref_d [2];
  logic [WW-1:0] fifo_nbr_q [2];
  logic [WW-1:0] fifo_nbr_d [2];
  logic [IW-1:0] fifo_i_q   [2];
  logic [IW-1:0] fifo_i_d   [2];
  logic [IW-1:0] fifo_j_q   [2];
  logic [IW-1:0] fifo_j_d   [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  logic          start_acc;
  logic          skip_in;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occ;
  logic [IW:0]   first_i, first_j;
  logic          first_valid;
  logic [IW:0]   adv_i, adv_j;
  logic          adv_valid;

`ifdef RL_PAIR_FEEDER_SKIP_SELF_EN
  assign skip_in = same_cell;
`else
  // same_cell has no effect when self-pair skipping is not built in.
  logic unused_same_cell;
  assign unused_same_cell = same_cell;
  assign skip_in          = 1'b0;
`endif

  assign start_acc = (state_q == S_IDLE) && start;
  assign pop       = (count_q != 2'd0) && iready;
  assign push      = inflight_q;

  // Slots already committed (buffered + returning) minus the one leaving now;
  // keeping this below 2 guarantees the returning word always has room.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (occ < 3'd2);

  // First pair of a pass, computed from the live inputs at start.
  // (0,0) is a self pair, so skipping starts the walk at j=1.
  always_comb begin
    first_i = '0;
    first_j = {{IW{1'b0}}, skip_in};
    if (first_j >= {1'b0, neighbor_num}) begin
      first_i = {{IW{1'b0}}, 1'b1};
      first_j = '0;
    end
    first_valid = (first_i < {1'b0, home_num}) && (neighbor_num != '0);
  end

  // Successor of the current pair. Self pairs are stepped over inside the
  // same cycle so skipping never costs a bubble. After a row wrap j=0 and
  // i>=1, so the wrapped pair is never a self pair.
  always_comb begin
    adv_i = {1'b0, i_q};
    adv_j = {1'b0, j_q} + {{IW{1'b0}}, 1'b1};
    if (skip_q && (adv_j == {1'b0, i_q})) begin
      adv_j = adv_j + {{IW{1'b0}}, 1'b1};
    end
    if (adv_j >= {1'b0, nbr_num_q}) begin
      adv_i = adv_i + {{IW{1'b0}}, 1'b1};
      adv_j = '0;
    end
    adv_valid = adv_i < {1'b0, home_num_q};
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = first_valid ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (issue && !adv_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count_d == 2'd0) && !inflight_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    done             = (state_q == S_DONE);
    ovalid           = (count_q != 2'd0);
    reference        = fifo_ref_q[rd_ptr_q];
    neighbor         = fifo_nbr_q[rd_ptr_q];
    ref_id           = fifo_i_q[rd_ptr_q];
    neighbor_id      = fifo_j_q[rd_ptr_q];
    home_rd_addr     = i_q;
    neighbor_rd_addr = j_q;
  end

  // Datapath next state: pair counters, read tags and output buffer.
  always_comb begin
    home_num_d = home_num_q;
    nbr_num_d  = nbr_num_q;
    skip_d     = skip_q;
    i_d        = i_q;
    j_d        = j_q;
    tag_i_d    = tag_i_q;
    tag_j_d    = tag_j_q;
    fifo_ref_d = fifo_ref_q;
    fifo_nbr_d = fifo_nbr_q;
    fifo_i_d   = fifo_i_q;
    fifo_j_d   = fifo_j_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;

    if (start_acc) begin
      home_num_d = home_num;
      nbr_num_d  = neighbor_num;
      skip_d     = skip_in;
      i_d        = first_i[IW-1:0];
      j_d        = first_j[IW-1:0];
    end

    if (issue) begin
      tag_i_d = i_q;
      tag_j_d = j_q;
      i_d     = adv_i[IW-1:0];
      j_d     = adv_j[IW-1:0];
    end

    if (push) begin
      fifo_ref_d[wr_ptr_q] = home_rd_data;
      fifo_nbr_d[wr_ptr_q] = neighbor_rd_data;
      fifo_i_d[wr_ptr_q]   = tag_i_q;
      fifo_j_d[wr_ptr_q]   = tag_j_q;
      wr_ptr_d             = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      home_num_q <= '0;
      nbr_num_q  <= '0;
      skip_q     <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      inflight_q <= 1'b0;
      tag_i_q    <= '0;
      tag_j_q    <= '0;
      fifo_ref_q <= '{default: '0};
      fifo_nbr_q <= '{default: '0};
      fifo_i_q   <= '{default: '0};
      fifo_j_q   <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      home_num_q <= home_num_d;
      nbr_num_q  <= nbr_num_d;
      skip_q     <= skip_d;
      i_q        <= i_d;
      j_q        <= j_d;
      inflight_q <= inflight_d;
      tag_i_q    <= tag_i_d;
      tag_j_q    <= tag_j_d;
      fifo_ref_q <= fifo_ref_d;
      fifo_nbr_q <= fifo_nbr_d;
      fifo_i_q   <= fifo_i_d;
      fifo_j_q   <= fifo_j_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_rl_pair_feeder.sv
// Bench for rl_pair_feeder: directed passes checked against a pair-list model
// (expected (i,j) order from nested loops, memory words from a formula) by one
// per-cycle compare process, plus hand-computed cycle numbers per pass.

module tb_rl_pair_feeder;

  localparam int DW = 32;
  localparam int IW = 7;
  localparam int WW = 4 * DW;

`ifdef RL_PAIR_FEEDER_SKIP_SELF_EN
  localparam int SAME_CELL_PAIRS = 6;
  localparam bit SKIP_BUILT      = 1'b1;
`else
  localparam int SAME_CELL_PAIRS = 9;
  localparam bit SKIP_BUILT      = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] home_num = '0;
  logic [IW-1:0] neighbor_num = '0;
  logic          same_cell = 1'b0;
  logic          iready = 1'b0;
  logic [IW-1:0] home_rd_addr, neighbor_rd_addr, ref_id, neighbor_id;
  logic [WW-1:0] home_rd_data, neighbor_rd_data, reference, neighbor;
  logic          ovalid, busy, done;

  rl_pair_feeder #(.DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IW)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .start            (start),
    .home_num         (home_num),
    .neighbor_num     (neighbor_num),
    .same_cell        (same_cell),
    .home_rd_addr     (home_rd_addr),
    .home_rd_data     (home_rd_data),
    .neighbor_rd_addr (neighbor_rd_addr),
    .neighbor_rd_data (neighbor_rd_data),
    .reference        (reference),
    .neighbor         (neighbor),
    .ref_id           (ref_id),
    .neighbor_id      (neighbor_id),
    .ovalid           (ovalid),
    .iready           (iready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  function automatic logic [WW-1:0] home_word(input int k);
    return {32'h3F80_0000 + 32'(k), 32'h4000_1000 + 32'(k * 3),
            32'h4100_2000 + 32'(k * 5), 32'h4200_3000 + 32'(k * 7)};
  endfunction

  function automatic logic [WW-1:0] nbr_word(input int k);
    return {32'hBF80_0000 + 32'(k * 11), 32'hC000_1000 + 32'(k * 13),
            32'hC100_2000 + 32'(k * 17), 32'hC200_3000 + 32'(k * 19)};
  endfunction

  // Memories with one cycle of read latency.
  always @(posedge clock) begin
    home_rd_data     <= home_word(int'(home_rd_addr));
    neighbor_rd_data <= nbr_word(int'(neighbor_rd_addr));
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0] i;
    logic [IW-1:0] j;
  } pair_t;

  pair_t         exp_q[$];
  int            start_cyc = 0;
  int            expect_done_at = -1;
  int            n_exp = 0;
  int            last_done_rel = -1;
  int            first_ov_rel = -1;
  int            xfer_cnt = 0;
  logic [2*IW-1:0] snap_ids = '0;
  bit            pass_open = 1'b0;
  bit            full_rate = 1'b0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_ref, prev_nbr;
  logic [IW-1:0] prev_i, prev_j;

  task automatic build_queue(input int h, input int n, input bit s);
    exp_q.delete();
    for (int i = 0; i < h; i++) begin
      for (int j = 0; j < n; j++) begin
        if (!(SKIP_BUILT && s && (i == j))) exp_q.push_back('{i: IW'(i), j: IW'(j)});
      end
    end
    n_exp = exp_q.size();
  endtask

  // Compare process: every cycle, DUT outputs against the pair-list model.
  always @(negedge clock) begin : mon
    int    rel;
    pair_t p;
    if (mon_en) begin
      rel = cyc - start_cyc;
      if (cyc == expect_done_at) pass_open = 1'b0;
      check("done", 128'(done), 128'(cyc == expect_done_at));
      if (done) last_done_rel = rel;
      check("busy", 128'(busy), 128'(pass_open && (cyc > start_cyc)));
      if (full_rate && pass_open)
        check("ovalid_timing", 128'(ovalid), 128'((rel >= 3) && (rel < 3 + n_exp)));
      if (prev_stall) begin
        check("hold_ovalid", 128'(ovalid), 128'(1));
        check("hold_reference", reference, prev_ref);
        check("hold_neighbor", neighbor, prev_nbr);
        check("hold_ref_id", 128'(ref_id), 128'(prev_i));
        check("hold_neighbor_id", 128'(neighbor_id), 128'(prev_j));
      end
      if (rel == 6) snap_ids = {ref_id, neighbor_id};
      if (ovalid && first_ov_rel < 0) first_ov_rel = rel;
      if (ovalid && iready) begin
        if (exp_q.size() == 0) begin
          check("extra_pair", 128'({ref_id, neighbor_id}), 128'(0));
        end else begin
          p = exp_q.pop_front();
          check("ref_id", 128'(ref_id), 128'(p.i));
          check("neighbor_id", 128'(neighbor_id), 128'(p.j));
          check("reference", reference, home_word(int'(p.i)));
          check("neighbor", neighbor, nbr_word(int'(p.j)));
          xfer_cnt++;
          if (exp_q.size() == 0) expect_done_at = cyc + 1;
        end
      end
      prev_stall = ovalid && !iready;
      prev_ref   = reference;
      prev_nbr   = neighbor;
      prev_i     = ref_id;
      prev_j     = neighbor_id;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ovalid"}, 128'(ovalid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_ref_id"}, 128'(ref_id), 128'(0));
    check({tag, "_neighbor_id"}, 128'(neighbor_id), 128'(0));
    check({tag, "_reference"}, reference, 128'(0));
    check({tag, "_neighbor"}, neighbor, 128'(0));
    check({tag, "_home_rd_addr"}, 128'(home_rd_addr), 128'(0));
    check({tag, "_neighbor_rd_addr"}, 128'(neighbor_rd_addr), 128'(0));
  endtask

  // Drives start for cycle 0 of a pass, then scrambles the count inputs.
  task automatic start_pass(input int h, input int n, input bit s, input bit fr);
    @(posedge clock); #1;
    home_num       = IW'(h);
    neighbor_num   = IW'(n);
    same_cell      = s;
    iready         = 1'b1;
    start          = 1'b1;
    build_queue(h, n, s);
    start_cyc      = cyc;
    full_rate      = fr;
    last_done_rel  = -1;
    first_ov_rel   = -1;
    xfer_cnt       = 0;
    expect_done_at = (n_exp == 0) ? cyc + 1 : -1;
    pass_open      = 1'b1;
    @(posedge clock); #1;
    start        = 1'b0;
    home_num     = 7'd9;
    neighbor_num = 7'd1;
    same_cell    = ~s;
  endtask

  task automatic run_pass(input int stall_lo, input int stall_hi, input int restart_at);
    int guard;
    int rel;
    guard = 0;
    while (pass_open && guard < 300) begin
      rel    = cyc - start_cyc;
      iready = !((rel >= stall_lo) && (rel <= stall_hi));
      start  = (rel == restart_at);
      if (rel == restart_at) begin
        home_num     = 7'd4;
        neighbor_num = 7'd4;
      end
      @(posedge clock); #1;
      guard++;
    end
    start  = 1'b0;
    iready = 1'b1;
    if (pass_open) begin
      check("pass_timeout", 128'(pass_open), 128'(0));
      pass_open = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);

    // 2x3 at full rate: pairs on cycles 3..8, done on 9.
    start_pass(2, 3, 1'b0, 1'b1);
    run_pass(-1, -1, -1);
    check("t1_first_ovalid_cycle", 128'(first_ov_rel), 128'(3));
    check("t1_done_cycle", 128'(last_done_rel), 128'(9));
    check("t1_pair_count", 128'(xfer_cnt), 128'(6));

    // 2x3 with iready low on cycles 4..8: (0,1) held, done on 14.
    start_pass(2, 3, 1'b0, 1'b0);
    run_pass(4, 8, -1);
    check("t2_held_pair", 128'(snap_ids), 128'({7'd0, 7'd1}));
    check("t2_first_ovalid_cycle", 128'(first_ov_rel), 128'(3));
    check("t2_done_cycle", 128'(last_done_rel), 128'(14));
    check("t2_pair_count", 128'(xfer_cnt), 128'(6));

    // 3x3 same cell.
    start_pass(3, 3, 1'b1, 1'b1);
    run_pass(-1, -1, -1);
    check("t3_pair_count", 128'(xfer_cnt), 128'(SAME_CELL_PAIRS));
    check("t3_done_cycle", 128'(last_done_rel), 128'(3 + SAME_CELL_PAIRS));

    // Zero home count.
    start_pass(0, 5, 1'b0, 1'b1);
    run_pass(-1, -1, -1);
    check("t4_done_cycle", 128'(last_done_rel), 128'(1));
    check("t4_pair_count", 128'(xfer_cnt), 128'(0));
    check("t4_no_ovalid", 128'(first_ov_rel), 128'(-1));

    // Reset at cycle 5 of a 4x4 pass, then a full fresh pass.
    start_pass(4, 4, 1'b0, 1'b1);
    repeat (4) begin @(posedge clock); #1; end
    resetn = 1'b0;
    @(posedge clock); #1;
    exp_q.delete();
    pass_open      = 1'b0;
    expect_done_at = -1;
    prev_stall     = 1'b0;
    resetn         = 1'b1;
    @(negedge clock);
    check_all_zero("midrun_reset");
    repeat (6) @(posedge clock);
    start_pass(4, 4, 1'b0, 1'b1);
    run_pass(-1, -1, -1);
    check("t5_pair_count", 128'(xfer_cnt), 128'(16));
    check("t5_done_cycle", 128'(last_done_rel), 128'(19));

    // Second start at cycle 4 with other counts is ignored.
    start_pass(2, 3, 1'b0, 1'b1);
    run_pass(-1, -1, 4);
    check("t6_pair_count", 128'(xfer_cnt), 128'(6));
    check("t6_done_cycle", 128'(last_done_rel), 128'(9));

    repeat (4) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
